// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 8-digit common-anode seven-segment driver with double-buffered data.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN suppresses leading-zero digits.
module seg7_scan_ctrl #(
   parameter int NUM_DIGITS   = 8,
   parameter int CLK_HZ       = 100_000_000,
   parameter int REFRESH_HZ   = 1000,
   parameter int BLANK_CYCLES = 100
) (
   input  logic                    CLK100MHZ,
   input  logic                    RST,
   input  logic                    locked,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   output logic [6:0]              seg_n,
   output logic                    dp_n,
   output logic [NUM_DIGITS-1:0]   AN,
   output logic                    frame_start
);

   localparam int SLOT = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
   localparam int CW   = (SLOT > 1) ? $clog2(SLOT) : 1;
   localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

   generate
      if (SLOT <= BLANK_CYCLES) begin : g_slot_chk
         $error("seg7_scan_ctrl: digit slot must be longer than the blanking gap");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

   state_t                         state, nxt_state;
   logic [CW-1:0]                  cnt, nxt_cnt;
   logic [IW-1:0]                  idx, nxt_idx;
   logic [NUM_DIGITS-1:0][3:0]     shadow_nib, active_nib;
   logic [NUM_DIGITS-1:0]          shadow_dp, active_dp, lz_blank;
   logic                           boundary;
   logic [6:0]                     nxt_seg;
   logic                           nxt_dp_n;
   logic [NUM_DIGITS-1:0]          nxt_an;

   function automatic logic [6:0] hex7(input logic [3:0] h);
      case (h)
         4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
         4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
         4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
         4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
      endcase
   endfunction

   // A digit is suppressed while it and every higher digit are zero with no dp lit.
   always_comb begin
      lz_blank = '0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      begin
         logic run;
         run = 1'b1;
         for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            run         = run & (active_nib[i] == 4'h0) & ~active_dp[i];
            lz_blank[i] = run;
         end
      end
`endif
   end

   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt;
      nxt_idx   = idx;
      case (state)
         IDLE: begin
            nxt_cnt = '0;
            nxt_idx = '0;
            if (locked) nxt_state = BLANK;
         end
         BLANK: begin
            nxt_cnt = cnt + 1'b1;
            if (cnt == BLANK_LAST) nxt_state = DRIVE;
         end
         DRIVE: begin
            if (cnt == SLOT_LAST) begin
               nxt_cnt   = '0;
               nxt_idx   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
               nxt_state = BLANK;
            end else begin
               nxt_cnt = cnt + 1'b1;
            end
         end
         default: begin
            nxt_state = IDLE;
            nxt_cnt   = '0;
            nxt_idx   = '0;
         end
      endcase
      if (!locked) begin
         nxt_state = IDLE;
         nxt_cnt   = '0;
         nxt_idx   = '0;
      end

      boundary = (nxt_state == BLANK) && (state != BLANK) && (nxt_idx == '0);

      // Outputs are computed for the state being entered so the pins carry no extra lag.
      nxt_seg  = 7'h7F;
      nxt_dp_n = 1'b1;
      nxt_an   = '1;
      if (nxt_state == DRIVE) begin
         nxt_seg  = hex7(active_nib[nxt_idx]);
         nxt_dp_n = ~active_dp[nxt_idx];
         if (digit_en[nxt_idx] && !lz_blank[nxt_idx]) nxt_an[nxt_idx] = 1'b0;
      end
   end

   always_ff @(posedge CLK100MHZ) begin
      if (RST) begin
         state       <= IDLE;
         cnt         <= '0;
         idx         <= '0;
         shadow_nib  <= '0;
         shadow_dp   <= '0;
         active_nib  <= '0;
         active_dp   <= '0;
         seg_n       <= 7'h7F;
         dp_n        <= 1'b1;
         AN          <= '1;
         frame_start <= 1'b0;
      end else begin
         state       <= nxt_state;
         cnt         <= nxt_cnt;
         idx         <= nxt_idx;
         if (load) begin
            shadow_nib <= data_in;
            shadow_dp  <= dp_in;
         end
         if (boundary) begin
            active_nib <= shadow_nib;
            active_dp  <= shadow_dp;
         end
         seg_n       <= nxt_seg;
         dp_n        <= nxt_dp_n;
         AN          <= nxt_an;
         frame_start <= boundary;
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: frame-arithmetic reference model, directed steps plus random traffic.
module tb_seg7_scan_ctrl;

   localparam int N          = 8;
   localparam int CLK_HZ     = 800;
   localparam int REFRESH_HZ = 10;
   localparam int BLANK      = 2;
   localparam int SLOT       = CLK_HZ / (REFRESH_HZ * N);
   localparam int FRAME      = SLOT * N;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           locked = 1'b0;
   logic           load = 1'b0;
   logic [4*N-1:0] data_in = '0;
   logic [N-1:0]   dp_in = '0;
   logic [N-1:0]   digit_en = '1;
   logic [6:0]     seg_n;
   logic           dp_n;
   logic [N-1:0]   AN;
   logic           frame_start;

   seg7_scan_ctrl #(
      .NUM_DIGITS(N), .CLK_HZ(CLK_HZ), .REFRESH_HZ(REFRESH_HZ), .BLANK_CYCLES(BLANK)
   ) dut (
      .CLK100MHZ(clk), .RST(rst), .locked(locked), .load(load), .data_in(data_in),
      .dp_in(dp_in), .digit_en(digit_en), .seg_n(seg_n), .dp_n(dp_n), .AN(AN),
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   // Reference model: time t counts cycles since the scan (re)started.
   bit             running = 1'b0;
   int             t = 0;
   logic [4*N-1:0] m_shadow = '0, m_active = '0;
   logic [N-1:0]   m_sdp = '0, m_adp = '0;
   logic [6:0]     hex_tab [16];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s at t=%0t observed=%h expected=%h", tag, $time, obs, exp);
   endtask

   task automatic tick();
      int         pos, slot;
      logic [6:0] e_seg;
      logic       e_dp, e_fs;
      logic [N-1:0] e_an;
      bit         lz;
      @(posedge clk);
      e_seg = 7'h7F; e_dp = 1'b1; e_an = '1; e_fs = 1'b0;
      if (rst) begin
         running = 1'b0;
         m_shadow = '0; m_active = '0; m_sdp = '0; m_adp = '0;
      end else begin
         if (!locked) running = 1'b0;
         else if (!running) begin running = 1'b1; t = 0; end
         else t++;
         if (running) begin
            pos  = t % FRAME;
            slot = pos / SLOT;
            if (pos == 0) begin
               m_active = m_shadow;
               m_adp    = m_sdp;
               e_fs     = 1'b1;
            end
            if ((pos % SLOT) >= BLANK) begin
               e_seg = hex_tab[m_active[4*slot +: 4]];
               e_dp  = ~m_adp[slot];
               lz    = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
               lz = (slot > 0) && ((m_active >> (4*slot)) == 0) && ((m_adp >> slot) == 0);
`endif
               if (digit_en[slot] && !lz) e_an[slot] = 1'b0;
            end
         end
         if (load) begin
            m_shadow = data_in;
            m_sdp    = dp_in;
         end
      end
      #1;
      chk("AN", 32'(AN), 32'(e_an));
      chk("seg_n", 32'(seg_n), 32'(e_seg));
      chk("dp_n", 32'(dp_n), 32'(e_dp));
      chk("frame_start", 32'(frame_start), 32'(e_fs));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_load(input logic [4*N-1:0] d, input logic [N-1:0] dp);
      data_in = d; dp_in = dp; load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   // Advance until the model sits at frame position target; an expired budget is a failure.
   task automatic wait_pos(input int target);
      int budget;
      budget = 3 * FRAME;
      while (!(running && (t % FRAME) == target) && budget > 0) begin
         tick();
         budget--;
      end
      if (budget == 0) begin
         checks++;
         $error("FAIL wait_pos observed=timeout expected=position %0d", target);
      end
   endtask

   initial begin
      hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

      // Reset with locked high; a load during reset must be ignored.
      rst = 1'b1; locked = 1'b1; digit_en = '1;
      data_in = $urandom; dp_in = 8'($urandom); load = 1'b1;
      run(3);
      load = 1'b0;
      rst = 1'b0;
      run(40);

      // Load before the next frame; digits 0/3/7 show d, A, 0 with dp on digit 0.
      do_load(32'h0123ABCD, 8'h01);
      run(FRAME + 20);

      // Mid-frame load only reaches the display at the next boundary.
      wait_pos(3*SLOT + 5);
      do_load(32'hFFFFFFFF, 8'h00);
      run(FRAME + 10);

      // Load landing exactly on a boundary is deferred one frame.
      wait_pos(FRAME - 1);
      do_load($urandom, 8'($urandom));
      run(2*FRAME);

      // Disabled low digits keep anodes off.
      digit_en = 8'hF0;
      run(FRAME);
      digit_en = 8'hFF;

      // Lock loss during slot 5, then restart at digit 0.
      wait_pos(5*SLOT + 4);
      locked = 1'b0;
      run(3);
      locked = 1'b1;
      run(FRAME + 5);

      // Leading-zero data; with dp on digit 4 the upper digits up to 4 stay relevant.
      do_load(32'h00000405, 8'h00);
      run(2*FRAME);
      do_load(32'h00000405, 8'h10);
      run(2*FRAME);
      do_load(32'h00000000, 8'h00);
      run(2*FRAME);

      // Random traffic with occasional loads, enable changes, lock drops and a reset.
      for (int i = 0; i < 1200; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            data_in = $urandom;
            if ($urandom_range(0, 1) == 0) data_in = data_in >> (4 * $urandom_range(0, 7));
            dp_in = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            load  = 1'b1;
         end
         if ($urandom_range(0, 49) == 0) digit_en = 8'($urandom);
         locked = ($urandom_range(0, 199) != 0);
         rst    = (i == 700);
         tick();
         load = 1'b0;
      end
      rst = 1'b0; locked = 1'b1;
      run(FRAME);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
